tick_period_meter: RTL and testbench
====================================

// Module: tick_period_meter
// PURPOSE
//  Receive-side counterpart of the reload/down-count tick timer: measures the clk-cycle
//  interval between rising edges of an event input and reports it as a reload value.
//  A tick stream from a timer loaded with N yields period == N on every sample.
//  Sits between an external/async event source and a valid/ready consumer (CSR block, log FIFO).
// PARAMETERS
//  BITS         8  width of the measured period and of the internal counter
//  SYNC_STAGES  2  synchroniser flops on evt_in (>=2)
// PORTS
//  clk           in   1     system clock, all logic rising-edge
//  rst           in   1     synchronous reset, active-low
//  en            in   1     measurement enable; 0 = abort measurement, return to IDLE
//  evt_in        in   1     event input, asynchronous to clk; rising edge = event
//  period        out  BITS  captured interval minus 1, in clk cycles
//  period_valid  out  1     period holds an unconsumed sample
//  period_ready  in   1     consumer accepts sample when valid&&ready
//  overflow      out  1     qualifies period: interval exceeded 2^BITS cycles, period saturated
//  missed        out  1     sticky: a capture was dropped because output was still full
//  clr_missed    in   1     one-cycle pulse clears missed
//  busy          out  1     1 while state==MEASURE
// BEHAVIOUR
//  Reset (rst==0 at clk edge): sync chain=0, edge-detect prev=0, state=IDLE, cnt=0,
//   period=0, period_valid=0, overflow=0, missed=0, busy=0. Reset wins over every other input.
//  Edge detect: evt_in -> SYNC_STAGES flops -> s; prev<=s; edge=s&~prev&en.
//   Fixed latency SYNC_STAGES+1 cycles evt_in->edge; the interval is unaffected.
//  FSM: IDLE  --edge--> MEASURE (cnt<=0, nothing captured: first edge only arms).
//       MEASURE --edge--> MEASURE (capture cnt and sat flag, cnt<=0, sat<=0).
//       any   --en==0--> IDLE (cnt<=0, sat<=0; pending output sample kept intact).
//  Counting (MEASURE, no edge): if cnt==2^BITS-1, hold cnt and set sat; else cnt<=cnt+1.
//   Edges P cycles apart capture cnt==P-1; P>2^BITS captures 2^BITS-1 with overflow=1.
//  Output slot (one entry): capture while !valid or (valid&&ready) -> period<=cnt,
//   overflow<=sat, valid<=1. Capture while valid&&!ready -> sample dropped, missed<=1,
//   period/overflow unchanged. valid&&ready with no capture -> valid<=0 (period/overflow hold).
//  period/overflow are stable whenever valid==1 and !ready (no change while stalled).
//  missed: set has priority over clr_missed in the same cycle.
//  Back-to-back edges (P=1 impossible after edge detect; min P=2) capture period=1.
//  en low mid-measurement: partial count discarded, no capture, no missed; next two edges
//   after en returns are needed for the first new sample.
// STRUCTURE
//  Shared package: FSM state encoding (ST_IDLE, ST_MEASURE) and the saturating-
//   increment function; reused by the timer family.
//  Sub-module: edge_sync (SYNC_STAGES synchroniser + rising-edge pulse), instantiated once.
//  Top: FSM, saturating counter, one-entry output register with valid/ready.
// TESTING
//  1 Reset: rst=0 for 3 cycles mid-activity -> all outputs 0, state IDLE, busy=0.
//  2 Drive evt_in from tick timer d_in=9, ready=1 -> first edge arms, then period=9,
//    overflow=0 on every sample, one valid pulse per 10 cycles.
//  3 BITS=8, edges 300 cycles apart -> period=255, overflow=1; next 20-cycle gap -> 19, overflow=0.
//  4 ready=0, edges every 10 cycles -> first sample 9 held, missed=1 after second capture;
//    ready=1 -> drained; clr_missed pulse -> missed=0; clr with same-cycle drop -> stays 1.
//  5 en=0 for 5 cycles mid-measurement -> busy=0, no capture; after en=1 edges 12 apart ->
//    first output after second edge, period=11.
//  6 Capture coinciding with valid&&ready -> new sample loaded, valid stays 1, missed=0.

Source files
------------

// File: rtl/tick_period_meter_pkg.sv
// Shared definitions for the tick timer family: FSM encoding, default sizes and
// the saturating-increment helper.
package tick_period_meter_pkg;

    localparam int unsigned BITS_DEF        = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CALC_W          = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    // Increment that sticks at max; callers cast to their own width (<= CALC_W).
    function automatic logic [CALC_W-1:0] sat_inc(input logic [CALC_W-1:0] v,
                                                  input logic [CALC_W-1:0] max);
        return (v >= max) ? max : v + CALC_W'(1);
    endfunction

endpackage

// File: rtl/tick_period_meter_if.sv
// Measured-period output channel: one-entry sample with valid/ready and overflow qualifier.
interface tick_period_meter_if
    import tick_period_meter_pkg::*;
#(
    parameter int unsigned BITS = BITS_DEF
);

    logic [BITS-1:0] period;
    logic            period_valid;
    logic            period_ready;
    logic            overflow;

    modport master (
        output period,
        output period_valid,
        output overflow,
        input  period_ready
    );

    modport slave (
        input  period,
        input  period_valid,
        input  overflow,
        output period_ready
    );

endinterface

// File: rtl/tick_period_meter_edge_sync.sv
// Synchronises the asynchronous event input and emits a one-cycle rising-edge pulse.
module tick_period_meter_edge_sync
    import tick_period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic evt_in,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], evt_in};
        prev_d = sync_q[SYNC_STAGES-1];
        edge_c = sync_q[SYNC_STAGES-1] & ~prev_q & en;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between event rising edges and reports them as a reload value
// (interval minus 1) through a one-entry valid/ready output slot.
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int unsigned BITS        = BITS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                evt_in,
    input  logic                clr_missed,
    output logic                missed,
    output logic                busy,
    tick_period_meter_if.master out_if
);

    localparam logic [BITS-1:0] CNT_MAX = '1;

    logic evt_edge;

    state_e          state_q, state_d;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic            sat_q, sat_d;
    logic [BITS-1:0] period_q, period_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic            missed_q, missed_d;
    logic            busy_q, busy_d;
    logic            capture;
    logic            drop;

    tick_period_meter_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .evt_in (evt_in),
        .edge_c (evt_edge)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        period_d = period_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        missed_d = missed_q;
        capture  = 1'b0;
        drop     = 1'b0;

        // Measurement FSM; first edge after IDLE only arms the counter.
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (evt_edge) begin
                state_d = ST_MEASURE;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
        end else begin
            if (evt_edge) begin
                capture = 1'b1;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = BITS'(sat_inc(CALC_W'(cnt_q), CALC_W'(CNT_MAX)));
            end
        end

        // Output slot: a capture into a stalled slot is dropped, keeping the held sample.
        if (capture) begin
            if (!valid_q || out_if.period_ready) begin
                period_d = cnt_q;
                ovf_d    = sat_q;
                valid_d  = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && out_if.period_ready) begin
            valid_d = 1'b0;
        end

        if (drop) begin
            missed_d = 1'b1;
        end else if (clr_missed) begin
            missed_d = 1'b0;
        end

        busy_d = (state_d == ST_MEASURE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            missed_q <= missed_d;
            busy_q   <= busy_d;
        end
    end

    assign out_if.period       = period_q;
    assign out_if.period_valid = valid_q;
    assign out_if.overflow     = ovf_q;
    assign missed              = missed_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: table of edge gaps plus hand-written corner sequences.
module tb_tick_period_meter;

    logic clk;
    logic rst;
    logic en;
    logic evt_in;
    logic clr_missed;
    logic missed;
    logic busy;

    int errors = 0;
    int checks = 0;

    tick_period_meter_if #(.BITS(8)) bus ();

    tick_period_meter #(
        .BITS        (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .evt_in     (evt_in),
        .clr_missed (clr_missed),
        .missed     (missed),
        .busy       (busy),
        .out_if     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        logic       o;
    } samp_t;

    typedef struct {
        int unsigned gap;
        logic [7:0]  exp_p;
        logic        exp_o;
    } vec_t;

    samp_t q[$];
    vec_t  vecs[9];

    // Record every accepted sample (valid && ready at the coming edge).
    always @(negedge clk) begin
        if (rst && bus.period_valid && bus.period_ready)
            q.push_back('{bus.period, bus.overflow});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        evt_in = 1'b1;
        step(1);
        evt_in = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_sample(input string name, input logic [7:0] p, input logic o);
        samp_t s;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no sample accepted, expected period %0d", name, p);
        end else begin
            s = q.pop_front();
            check({name, " period"}, 32'(s.p), 32'(p));
            check({name, " overflow"}, 32'(s.o), 32'(o));
        end
    endtask

    // Return to IDLE with an empty output slot.
    task automatic prep();
        en = 1'b0;
        bus.period_ready = 1'b1;
        clr_missed = 1'b1;
        step(3);
        clr_missed = 1'b0;
        en = 1'b1;
        step(1);
        q.delete();
    endtask

    initial begin
        vecs[0] = '{10,  8'd9,   1'b0};
        vecs[1] = '{10,  8'd9,   1'b0};
        vecs[2] = '{10,  8'd9,   1'b0};
        vecs[3] = '{2,   8'd1,   1'b0};
        vecs[4] = '{3,   8'd2,   1'b0};
        vecs[5] = '{256, 8'd255, 1'b0};
        vecs[6] = '{257, 8'd255, 1'b1};
        vecs[7] = '{300, 8'd255, 1'b1};
        vecs[8] = '{20,  8'd19,  1'b0};

        rst = 1'b0;
        en = 1'b0;
        evt_in = 1'b0;
        clr_missed = 1'b0;
        bus.period_ready = 1'b0;
        step(2);
        check("por valid", 32'(bus.period_valid), 32'd0);
        check("por period", 32'(bus.period), 32'd0);
        check("por busy", 32'(busy), 32'd0);
        rst = 1'b1;
        step(1);

        // Table of edge gaps, ready held high; each gap P yields min(P-1,255).
        prep();
        for (int i = 0; i < 9; i++) begin
            pulse();
            step(int'(vecs[i].gap) - 1);
        end
        pulse();
        step(6);
        check("table count", 32'(q.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            expect_sample($sformatf("table[%0d]", i), vecs[i].exp_p, vecs[i].exp_o);

        // Stalled consumer: first sample held, second dropped -> missed.
        prep();
        bus.period_ready = 1'b0;
        pulse();
        step(9);
        pulse();
        step(14);
        pulse();
        step(4);
        check("stall valid", 32'(bus.period_valid), 32'd1);
        check("stall period", 32'(bus.period), 32'd9);
        check("stall overflow", 32'(bus.overflow), 32'd0);
        check("stall missed", 32'(missed), 32'd1);
        bus.period_ready = 1'b1;
        step(1);
        bus.period_ready = 1'b0;
        check("drain valid", 32'(bus.period_valid), 32'd0);
        expect_sample("drain", 8'd9, 1'b0);
        check("missed kept", 32'(missed), 32'd1);
        clr_missed = 1'b1;
        step(1);
        clr_missed = 1'b0;
        check("missed cleared", 32'(missed), 32'd0);
        pulse();
        step(5);
        check("reload valid", 32'(bus.period_valid), 32'd1);
        check("reload missed", 32'(missed), 32'd0);
        // Clear pulse lands on the same edge as a dropped capture.
        evt_in = 1'b1;
        step(1);
        evt_in = 1'b0;
        step(1);
        clr_missed = 1'b1;
        step(1);
        clr_missed = 1'b0;
        check("set beats clr", 32'(missed), 32'd1);

        // Enable dropped mid-measurement discards the partial count.
        prep();
        pulse();
        step(5);
        check("en busy", 32'(busy), 32'd1);
        en = 1'b0;
        step(1);
        check("en off busy", 32'(busy), 32'd0);
        pulse();
        step(3);
        en = 1'b1;
        step(1);
        check("en back idle", 32'(busy), 32'd0);
        check("en off no sample", 32'(q.size()), 32'd0);
        pulse();
        step(11);
        check("re-arm no sample", 32'(q.size()), 32'd0);
        pulse();
        step(4);
        expect_sample("en restart", 8'd11, 1'b0);

        // Capture on the same edge the held sample is accepted.
        prep();
        bus.period_ready = 1'b0;
        pulse();
        step(9);
        pulse();
        step(6);
        evt_in = 1'b1;
        step(1);
        evt_in = 1'b0;
        step(1);
        bus.period_ready = 1'b1;
        step(1);
        check("coincide valid", 32'(bus.period_valid), 32'd1);
        check("coincide period", 32'(bus.period), 32'd6);
        check("coincide missed", 32'(missed), 32'd0);
        expect_sample("coincide old", 8'd9, 1'b0);
        step(1);
        check("coincide drained", 32'(bus.period_valid), 32'd0);
        expect_sample("coincide new", 8'd6, 1'b0);

        // Reset mid-activity with a held sample, missed set and measurement running.
        prep();
        bus.period_ready = 1'b0;
        pulse();
        step(9);
        pulse();
        step(9);
        pulse();
        step(5);
        check("pre-rst missed", 32'(missed), 32'd1);
        rst = 1'b0;
        step(3);
        check("rst period", 32'(bus.period), 32'd0);
        check("rst valid", 32'(bus.period_valid), 32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        check("rst missed", 32'(missed), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst = 1'b1;
        bus.period_ready = 1'b1;
        step(2);
        q.delete();
        pulse();
        step(5);
        check("post-rst arm busy", 32'(busy), 32'd1);
        check("post-rst arm no sample", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
